// File: rtl/ndn_prefix_tx.sv
// NDN name-prefix serializer: queues (prefix, len) requests and emits each prefix
// MSB-first as LANE_W-bit beats framed by tx_sof/tx_eof.
module ndn_prefix_tx #(
    parameter int PREFIX_W = 64,
    parameter int LEN_W    = 7,
    parameter int LANE_W   = 1,
    parameter int DEPTH    = 4,
    localparam int BITS_W  = $clog2(LANE_W) + 1,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PREFIX_W-1:0] prefix,
    input  logic [LEN_W-1:0]    len,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [LANE_W-1:0]   tx_data,
    output logic [BITS_W-1:0]   tx_bits,
    output logic                tx_sof,
    output logic                tx_eof,
    output logic [LEN_W-1:0]    tx_len,
    output logic [CNT_W-1:0]    q_count,
    output logic [15:0]         frames_sent,
    output logic                fsm_state
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid=1 and ready=1.
    // Once tx_valid is high, the beat (data/bits/sof/eof) holds until it transfers;
    // in_ready depends only on queue occupancy, never on tx_ready or a same-cycle pop.

    state_t state, next_state;

    logic [PREFIX_W-1:0] q_prefix [DEPTH];
    logic [LEN_W-1:0]    q_len    [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;

    logic [PREFIX_W-1:0] shreg;
    logic [LEN_W-1:0]    rem;
    logic [LEN_W-1:0]    cur_len;
    logic                first_beat;
    logic [15:0]         frame_cnt;

    logic                push, pop, load;
    logic                beat_xfer, last_beat, eof_xfer;
    logic [LEN_W-1:0]    len_clamped;
    logic [LEN_W-1:0]    head_len;
    logic [PREFIX_W-1:0] head_prefix;

    assign in_ready    = (count < CNT_W'(DEPTH));
    assign push        = in_valid && in_ready;
    assign len_clamped = (len > LEN_W'(PREFIX_W)) ? LEN_W'(PREFIX_W) : len;
    assign head_len    = q_len[rd_ptr];
    assign head_prefix = q_prefix[rd_ptr];

    assign beat_xfer = (state == SEND) && tx_ready;
    assign last_beat = (rem <= LEN_W'(LANE_W));
    assign eof_xfer  = beat_xfer && last_beat;

    // Request queue storage; occupancy is tracked by count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            q_prefix[wr_ptr] <= prefix;
            q_len[wr_ptr]    <= len_clamped;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // A zero-length head is popped and dropped; the last beat of a frame can
    // pop the next request on the same edge so frames run back to back.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (head_len != '0) begin
                        load       = 1'b1;
                        next_state = SEND;
                    end
                end
            end
            SEND: begin
                if (eof_xfer) begin
                    if (count != '0) begin
                        pop = 1'b1;
                        if (head_len != '0) load = 1'b1;
                        else                next_state = IDLE;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg      <= '0;
            rem        <= '0;
            cur_len    <= '0;
            first_beat <= 1'b0;
        end else if (load) begin
            shreg      <= head_prefix << (LEN_W'(PREFIX_W) - head_len);
            rem        <= head_len;
            cur_len    <= head_len;
            first_beat <= 1'b1;
        end else if (beat_xfer) begin
            shreg      <= shreg << LANE_W;
            rem        <= rem - LEN_W'(LANE_W);
            first_beat <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          frame_cnt <= '0;
        else if (eof_xfer) frame_cnt <= frame_cnt + 16'd1;
    end

    // Zeros shifted in behind the prefix keep unused bits of a short last beat clear.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_bits  = '0;
        tx_sof   = 1'b0;
        tx_eof   = 1'b0;
        if (state == SEND) begin
            tx_valid = 1'b1;
            tx_data  = shreg[PREFIX_W-1 -: LANE_W];
            tx_bits  = last_beat ? BITS_W'(rem) : BITS_W'(LANE_W);
            tx_sof   = first_beat;
            tx_eof   = last_beat;
        end
    end

    assign tx_len      = cur_len;
    assign q_count     = count;
    assign frames_sent = frame_cnt;
    assign fsm_state   = (state == SEND);

endmodule

// File: tb/tb_ndn_prefix_tx.sv
// Bench for ndn_prefix_tx: one serial-lane and one 4-bit-lane instance share the
// request stream; each has its own expected-beat queue fed by a bit-level model.
module tb_ndn_prefix_tx;

    localparam int W = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v1, v4;
    logic [63:0] prefix;
    logic [6:0]  len;
    logic        tx_ready;

    logic        in_ready1, tx_valid1, sof1, eof1, st1;
    logic [0:0]  tx_data1, tx_bits1;
    logic [6:0]  tx_len1;
    logic [2:0]  q_count1;
    logic [15:0] frames1;

    logic        in_ready4, tx_valid4, sof4, eof4, st4;
    logic [3:0]  tx_data4;
    logic [2:0]  tx_bits4;
    logic [6:0]  tx_len4;
    logic [2:0]  q_count4;
    logic [15:0] frames4;

    ndn_prefix_tx #(.PREFIX_W(64), .LEN_W(7), .LANE_W(1), .DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(in_ready1),
        .prefix(prefix), .len(len), .tx_valid(tx_valid1), .tx_ready(tx_ready),
        .tx_data(tx_data1), .tx_bits(tx_bits1), .tx_sof(sof1), .tx_eof(eof1),
        .tx_len(tx_len1), .q_count(q_count1), .frames_sent(frames1), .fsm_state(st1)
    );

    ndn_prefix_tx #(.PREFIX_W(64), .LEN_W(7), .LANE_W(4), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(in_ready4),
        .prefix(prefix), .len(len), .tx_valid(tx_valid4), .tx_ready(tx_ready),
        .tx_data(tx_data4), .tx_bits(tx_bits4), .tx_sof(sof4), .tx_eof(eof4),
        .tx_len(tx_len4), .q_count(q_count4), .frames_sent(frames4), .fsm_state(st4)
    );

    int checks = 0;
    int failures = 0;
    int exp_frames1 = 0;
    int exp_frames4 = 0;
    logic [W-1:0] exp1_q[$];
    logic [W-1:0] exp4_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [6:0] l, input logic [3:0] b,
                                          input logic [3:0] d, input logic s, input logic e);
        return {l, b, d, s, e};
    endfunction

    // Frame bit i (i = 0 is sent first) is prefix[L-1-i]; beats fill lane MSB first.
    task automatic push_frames(input logic [63:0] p, input logic [6:0] l);
        int L;
        L = (l > 7'd64) ? 64 : int'(l);
        for (int li = 0; li < 2; li++) begin
            int lane;
            int beats;
            lane  = (li == 0) ? 1 : 4;
            beats = (L + lane - 1) / lane;
            for (int b = 0; b < beats; b++) begin
                logic [3:0] d;
                int bits;
                d = 4'd0;
                for (int k = 0; k < lane; k++) begin
                    int idx;
                    idx = b * lane + k;
                    if (idx < L) d[lane-1-k] = p[L-1-idx];
                end
                bits = ((L - b * lane) < lane) ? (L - b * lane) : lane;
                if (li == 0) exp1_q.push_back(pack(7'(L), 4'(bits), d, b == 0, b == beats - 1));
                else         exp4_q.push_back(pack(7'(L), 4'(bits), d, b == 0, b == beats - 1));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst && tx_valid1) begin
            if (exp1_q.size() == 0) begin
                check("dut1_unexpected_beat", 64'(tx_valid1), 64'd0);
            end else begin
                check("dut1_beat", 64'(pack(tx_len1, 4'(tx_bits1), 4'(tx_data1), sof1, eof1)),
                      64'(exp1_q[0]));
                if (tx_ready) begin
                    if (exp1_q[0][0]) exp_frames1++;
                    void'(exp1_q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && tx_valid4) begin
            if (exp4_q.size() == 0) begin
                check("dut4_unexpected_beat", 64'(tx_valid4), 64'd0);
            end else begin
                check("dut4_beat", 64'(pack(tx_len4, 4'(tx_bits4), tx_data4, sof4, eof4)),
                      64'(exp4_q[0]));
                if (tx_ready) begin
                    if (exp4_q[0][0]) exp_frames4++;
                    void'(exp4_q.pop_front());
                end
            end
        end
    end

    task automatic wait_accept();
        int n;
        logic a1, a4;
        n = 0;
        while ((v1 || v4) && n < 2000) begin
            a1 = v1 && in_ready1;
            a4 = v4 && in_ready4;
            @(posedge clk);
            #1;
            if (a1) v1 = 1'b0;
            if (a4) v4 = 1'b0;
            n++;
        end
        check("accept_timeout", 64'(v1 || v4), 64'd0);
        v1 = 1'b0;
        v4 = 1'b0;
    endtask

    task automatic send(input logic [63:0] p, input logic [6:0] l);
        prefix = p;
        len    = l;
        push_frames(p, l);
        v1 = 1'b1;
        v4 = 1'b1;
        wait_accept();
    endtask

    task automatic wait_drain(input bit rnd);
        int n;
        n = 0;
        while ((exp1_q.size() != 0 || exp4_q.size() != 0) && n < 3000) begin
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        tx_ready = 1'b1;
        check("drain_dut1", 64'(exp1_q.size()), 64'd0);
        check("drain_dut4", 64'(exp4_q.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("frames_dut1", 64'(frames1), 64'(exp_frames1));
        check("frames_dut4", 64'(frames4), 64'(exp_frames4));
        check("q_empty_dut1", 64'(q_count1), 64'd0);
        check("q_empty_dut4", 64'(q_count4), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready1"}, 64'(in_ready1), 64'd1);
        check({tag, "_in_ready4"}, 64'(in_ready4), 64'd1);
        check({tag, "_outs1"}, 64'({tx_valid1, tx_data1, tx_bits1, sof1, eof1, tx_len1, st1}), 64'd0);
        check({tag, "_outs4"}, 64'({tx_valid4, tx_data4, tx_bits4, sof4, eof4, tx_len4, st4}), 64'd0);
        check({tag, "_q_count1"}, 64'(q_count1), 64'd0);
        check({tag, "_q_count4"}, 64'(q_count4), 64'd0);
        check({tag, "_frames1"}, 64'(frames1), 64'd0);
        check({tag, "_frames4"}, 64'(frames4), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; v1 = 1'b0; v4 = 1'b0; prefix = '0; len = '0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Single frame into an empty idle queue: first beat one edge after acceptance.
        tx_ready = 1'b1;
        prefix = 64'd28; len = 7'd5;
        push_frames(64'd28, 7'd5);
        v1 = 1'b1; v4 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0; v4 = 1'b0;
        check("lat_q_count1", 64'(q_count1), 64'd1);
        check("lat_valid_early", 64'(tx_valid1), 64'd0);
        @(posedge clk); #1;
        check("lat_valid1", 64'({tx_valid1, sof1}), 64'd3);
        check("lat_valid4", 64'({tx_valid4, sof4}), 64'd3);
        wait_drain(1'b0);
        check("frames_after_first", 64'(frames1), 64'd1);

        // Two queued frames: sof of the second directly follows eof of the first.
        tx_ready = 1'b0;
        send(64'd28, 7'd5);
        send(64'h2d, 7'd6);
        tx_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(tx_valid1 && eof1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_eof_seen", 64'(tx_valid1 && eof1), 64'd1);
        @(negedge clk);
        check("b2b_sof", 64'({tx_valid1, sof1}), 64'd3);
        wait_drain(1'b0);

        // Queue fill behind a stalled frame: four accepted, fifth waits for tx_ready.
        tx_ready = 1'b0;
        send(64'h5, 7'd3);
        repeat (2) @(posedge clk);
        #1;
        check("fill_start_q1", 64'(q_count1), 64'd0);
        for (int i = 0; i < 4; i++) send({$urandom, $urandom}, 7'($urandom_range(1, 64)));
        check("full_in_ready1", 64'(in_ready1), 64'd0);
        check("full_in_ready4", 64'(in_ready4), 64'd0);
        check("full_q_count1", 64'(q_count1), 64'd4);
        check("full_q_count4", 64'(q_count4), 64'd4);
        prefix = 64'hbeef; len = 7'd16;
        push_frames(64'hbeef, 7'd16);
        v1 = 1'b1; v4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("fifth_held_q1", 64'(q_count1), 64'd4);
        check("fifth_held_v1", 64'(v1), 64'd1);
        tx_ready = 1'b1;
        wait_accept();
        wait_drain(1'b0);

        // Over-long length clamps to 64; zero length produces nothing.
        send({$urandom, $urandom}, 7'd70);
        @(posedge clk); #1;
        check("clamp_tx_len1", 64'(tx_len1), 64'd64);
        check("clamp_tx_len4", 64'(tx_len4), 64'd64);
        wait_drain(1'b0);
        n = exp_frames1;
        send(64'hffff, 7'd0);
        wait_drain(1'b0);
        check("zero_len_frames", 64'(frames1), 64'(n));

        // Random requests with random backpressure.
        for (int r = 0; r < 2; r++) begin
            tx_ready = 1'b0;
            for (int i = 0; i < 3; i++) send({$urandom, $urandom}, 7'($urandom_range(0, 72)));
            wait_drain(1'b1);
        end

        // Reset during beat 3 of 5, then a normal frame.
        tx_ready = 1'b1;
        send(64'd28, 7'd5);
        repeat (3) @(posedge clk);
        #1;
        check("mid_frame_active", 64'(tx_valid1), 64'd1);
        rst = 1'b0;
        exp1_q.delete();
        exp4_q.delete();
        exp_frames1 = 0;
        exp_frames4 = 0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        send(64'hb5, 7'd8);
        wait_drain(1'b0);
        check("post_reset_frames", 64'(frames1), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
